alu_mdu: RTL

Parametrised, registered integer ALU with an iterative multiply/divide unit and a valid/ready operand handshake. It extends the 2-bit ADD/SUB/AND/POPCOUNT ALU with logic ops, an unsigned multiply and an unsigned divide. Single-cycle ops sustain one result per clock. MUL/DIV stall the input for WIDTH cycles. It sits between an operand sequencer and a result register file / flag consumer.

---
 rtl/alu_mdu.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: registered integer ALU with an iterative unsigned multiply/divide unit.
//   i_CLK, i_RSTn      : clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready  : operand handshake; accept = i_valid && o_ready at a rising edge
//   i_oper             : 000 ADD, 001 SUB, 010 AND, 011 POPCNT, 100 OR, 101 XOR, 110 MUL, 111 DIV
//   i_arg0 / i_arg1    : operands A / B
//   o_valid            : one-cycle pulse when o_result / o_result_hi / o_flag are updated
//   o_result           : low result / quotient
//   o_result_hi        : MUL high half / DIV remainder, zero for other ops
//   o_flag             : {DZ, Z, C, V}
// Single-cycle ops complete one edge after accept. MUL/DIV occupy the block for WIDTH
// iterations and complete at the WIDTH-th edge after accept.
module alu_mdu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_oper,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic [3:0]       o_flag
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned CW  = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned PCW = $clog2(PW + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_POP = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;         // MUL partial-product high / DIV partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;         // MUL multiplier/product low / DIV dividend/quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;     // MUL multiplicand / DIV divisor
    logic             is_div_q, is_div_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [3:0]       flag_q, flag_d;

    // Single-cycle datapath, evaluated straight from the input operands
    logic [WIDTH:0]   add_w, sub_w;
    logic [PW-1:0]    pop_src;
    logic [PCW-1:0]   pop_cnt;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_c, sc_v, sc_dz;

    always_comb begin
        add_w   = {1'b0, i_arg0} + {1'b0, i_arg1};
        sub_w   = {1'b0, i_arg0} - {1'b0, i_arg1};
        pop_src = {i_arg1, i_arg0};
        pop_cnt = '0;
        sc_res  = '0;
        sc_hi   = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_dz   = 1'b0;
        for (int i = 0; i < int'(PW); i++) begin
            pop_cnt = pop_cnt + PCW'(pop_src[i]);
        end
        case (i_oper)
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_c   = add_w[WIDTH];
                sc_v   = (i_arg0[MSB] == i_arg1[MSB]) && (add_w[MSB] != i_arg0[MSB]);
            end
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_c   = sub_w[WIDTH];    // borrow out == A < B unsigned
                sc_v   = (i_arg0[MSB] != i_arg1[MSB]) && (sub_w[MSB] != i_arg0[MSB]);
            end
            OP_AND: sc_res = i_arg0 & i_arg1;
            OP_POP: sc_res = WIDTH'(pop_cnt);
            OP_OR:  sc_res = i_arg0 | i_arg1;
            OP_XOR: sc_res = i_arg0 ^ i_arg1;
            OP_DIV: begin
                // Only reached as a single-cycle op when the divisor is zero
                sc_res = '1;
                sc_hi  = i_arg0;
                sc_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    // One MUL or DIV iteration from the current working registers
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh  = {hi_q, lo_q[MSB]};
        div_ge  = div_sh >= {1'b0, opnd_q};
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (is_div_q) begin
            // Remainder < divisor, so a WIDTH-bit subtract is exact
            step_hi = div_ge ? (div_sh[WIDTH-1:0] - opnd_q) : div_sh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        valid_d     = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flag_d      = flag_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (i_oper == OP_MUL) begin
                        state_d  = BUSY;
                        cnt_d    = CW'(WIDTH - 1);
                        hi_d     = '0;
                        lo_d     = i_arg1;
                        opnd_d   = i_arg0;
                        is_div_d = 1'b0;
                    end else if (i_oper == OP_DIV && i_arg1 != '0) begin
                        state_d  = BUSY;
                        cnt_d    = CW'(WIDTH - 1);
                        hi_d     = '0;
                        lo_d     = i_arg0;
                        opnd_d   = i_arg1;
                        is_div_d = 1'b1;
                    end else begin
                        valid_d     = 1'b1;
                        result_d    = sc_res;
                        result_hi_d = sc_hi;
                        flag_d      = {sc_dz, (sc_res == '0) && !sc_dz, sc_c, sc_v};
                    end
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    valid_d     = 1'b1;
                    result_d    = step_lo;
                    result_hi_d = step_hi;
                    if (is_div_q) begin
                        flag_d = {1'b0, step_lo == '0, 1'b0, 1'b0};
                    end else begin
                        flag_d = {1'b0, {step_hi, step_lo} == '0, step_hi != '0, 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flag_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flag_q      <= flag_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_result_hi = result_hi_q;
    assign o_flag      = flag_q;

endmodule
